// File: rtl/rot_pkg.sv
// Shared constants, state encodings and operand record for the rotate arbiter.
// Also holds the left-to-right amount mapping used ahead of the right rotator.
package rot_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic              dir;
  } rot_op_t;

  // A left rotate by n equals a right rotate by (32 - n) mod 32.
  function automatic logic [AMT_W-1:0] eff_amt(input logic [AMT_W-1:0] amt,
                                               input logic             dir);
    logic [AMT_W-1:0] eff;
    eff = amt;
    case (dir)
      DIR_RIGHT: eff = amt;
      DIR_LEFT:  eff = {AMT_W{1'b0}} - amt;
    endcase
    return eff;
  endfunction

endpackage

// File: rtl/rot_arbiter_if.sv
// Request and response channels for both requesters of the rotate arbiter.
// master = requester side, slave = arbiter side.
interface rot_arbiter_if;
  import rot_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [AMT_W-1:0]  req0_amt;
  logic              req0_dir;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [AMT_W-1:0]  req1_amt;
  logic              req1_dir;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_data;

  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_data;

  modport master (
    output req0_valid, req0_data, req0_amt, req0_dir,
    input  req0_ready,
    output req1_valid, req1_data, req1_amt, req1_dir,
    input  req1_ready,
    input  rsp0_valid, rsp0_data,
    output rsp0_ready,
    input  rsp1_valid, rsp1_data,
    output rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req0_amt, req0_dir,
    output req0_ready,
    input  req1_valid, req1_data, req1_amt, req1_dir,
    output req1_ready,
    output rsp0_valid, rsp0_data,
    input  rsp0_ready,
    output rsp1_valid, rsp1_data,
    input  rsp1_ready
  );

endinterface

// File: rtl/rot_core.sv
// Purely combinational 32-bit right rotator.
module rot_core
  import rot_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] dout
);

  // amt = 0 makes the left shift 32, which clears that term as needed.
  always_comb begin
    dout = (din >> amt) | (din << (6'd32 - {1'b0, amt}));
  end

endmodule

// File: rtl/rot_arbiter.sv
// Round-robin arbiter sharing one right rotator between two requesters;
// one operation in flight, result held per requester until accepted.
module rot_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              clear,
  rot_arbiter_if.slave      bus,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);
  import rot_pkg::*;

  logic [1:0]        state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  rot_op_t           op_q, op_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;
  logic [CNT_W-1:0]  ops_done_q, ops_done_d;

  logic              grant0, grant1, rsp_fire;
  logic [AMT_W-1:0]  rot_amt;
  logic [DATA_W-1:0] rot_out;

  // On a tie the requester matching prio wins; prio flips away from each served owner.
  always_comb begin
    grant0 = (state_q == IDLE) & bus.req0_valid & (~bus.req1_valid | ~prio_q);
    grant1 = (state_q == IDLE) & bus.req1_valid & (~bus.req0_valid |  prio_q);
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_data  = rsp1_data_q;
  assign busy           = (state_q != IDLE);
  assign ops_done       = ops_done_q;

  always_comb begin
    rot_amt  = eff_amt(op_q.amt, op_q.dir);
    rsp_fire = (state_q == HOLD) &
               (owner_q ? (rsp1_valid_q & bus.rsp1_ready)
                        : (rsp0_valid_q & bus.rsp0_ready));
  end

  rot_core u_core (
    .din  (op_q.data),
    .amt  (rot_amt),
    .dout (rot_out)
  );

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    owner_d      = owner_q;
    op_d         = op_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    ops_done_d   = ops_done_q;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          op_d    = '{data: bus.req0_data, amt: bus.req0_amt, dir: bus.req0_dir};
          owner_d = 1'b0;
          state_d = EXEC;
        end else if (grant1) begin
          op_d    = '{data: bus.req1_data, amt: bus.req1_amt, dir: bus.req1_dir};
          owner_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (owner_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_data_d  = rot_out;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_data_d  = rot_out;
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (rsp_fire) begin
          if (owner_q) rsp1_valid_d = 1'b0;
          else         rsp0_valid_d = 1'b0;
          ops_done_d = ops_done_q + CNT_W'(1);
          prio_d     = ~owner_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      op_q         <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      ops_done_q   <= ops_done_d;
    end
  end

endmodule

// File: tb/tb_rot_arbiter.sv
// Directed bench for rot_arbiter: rotate mapping, arbitration, backpressure,
// mid-operation reset and counter wrap (counter built 4 bits wide).
module tb_rot_arbiter;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       busy;
  logic [3:0] ops_done;
  int         n_checks = 0;
  int         n_fail   = 0;

  rot_arbiter_if bus ();

  rot_arbiter #(.DATA_W(32), .CNT_W(4)) dut (
    .clock    (clock),
    .clear    (clear),
    .bus      (bus),
    .busy     (busy),
    .ops_done (ops_done)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic set_req(input int n, input logic v, input logic [31:0] d,
                         input logic [4:0] a, input logic dir);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_amt = a; bus.req0_dir = dir;
    end else begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_amt = a; bus.req1_dir = dir;
    end
  endtask

  task automatic set_rsp_ready(input int n, input logic v);
    if (n == 0) bus.rsp0_ready = v;
    else        bus.rsp1_ready = v;
  endtask

  function automatic logic req_rdy(input int n);
    return (n == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic rsp_vld(input int n);
    return (n == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  function automatic logic [31:0] rsp_dat(input int n);
    return (n == 0) ? bus.rsp0_data : bus.rsp1_data;
  endfunction

  // One complete operation on requester n with the response taken immediately.
  task automatic run_op(input string tag, input int n, input logic [31:0] d,
                        input logic [4:0] a, input logic dir, input logic [31:0] exp);
    int k;
    tick();
    set_req(n, 1'b1, d, a, dir);
    set_rsp_ready(n, 1'b1);
    sample();
    k = 0;
    while (!req_rdy(n) && k < 10) begin sample(); k++; end
    chk({tag, "_ready"}, {31'd0, req_rdy(n)}, 32'd1);
    tick();
    set_req(n, 1'b0, d, a, dir);
    sample();
    k = 0;
    while (!rsp_vld(n) && k < 10) begin sample(); k++; end
    chk({tag, "_data"}, rsp_dat(n), exp);
    tick();
    set_rsp_ready(n, 1'b0);
  endtask

  initial begin
    set_req(0, 1'b0, 32'd0, 5'd0, 1'b0);
    set_req(1, 1'b0, 32'd0, 5'd0, 1'b0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // 1: reset and basic right rotate
    tick(); tick();
    sample();
    chk("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    chk("rst_rsp0_data", bus.rsp0_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ops_done", {28'd0, ops_done}, 32'd0);
    clear = 1'b1;
    tick();
    set_req(0, 1'b1, 32'h0000_0001, 5'd1, 1'b0);
    bus.rsp0_ready = 1'b1;
    sample();
    chk("t1_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    set_req(0, 1'b0, 32'h0000_0001, 5'd1, 1'b0);
    sample();
    chk("t1_busy_exec", {31'd0, busy}, 32'd1);
    chk("t1_rsp0_valid_exec", {31'd0, bus.rsp0_valid}, 32'd0);
    tick();
    sample();
    chk("t1_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
    chk("t1_rsp0_data", bus.rsp0_data, 32'h8000_0000);
    chk("t1_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    tick();
    bus.rsp0_ready = 1'b0;
    sample();
    chk("t1_ops_done", {28'd0, ops_done}, 32'd1);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);
    chk("t1_rsp0_valid_clr", {31'd0, bus.rsp0_valid}, 32'd0);
    chk("t1_rsp0_data_keep", bus.rsp0_data, 32'h8000_0000);

    // 2: left rotate mapping and zero amounts
    run_op("t2_l8", 1, 32'h0000_000F, 5'd8, 1'b1, 32'h0000_0F00);
    run_op("t2_l1", 0, 32'h8000_0000, 5'd1, 1'b1, 32'h0000_0001);
    run_op("t2_l4", 1, 32'h1234_5678, 5'd4, 1'b1, 32'h2345_6781);
    run_op("t2_r0", 0, 32'hA5A5_1234, 5'd0, 1'b0, 32'hA5A5_1234);
    run_op("t2_l0", 1, 32'hA5A5_1234, 5'd0, 1'b1, 32'hA5A5_1234);
    run_op("t2_r31", 0, 32'h0000_0001, 5'd31, 1'b0, 32'h0000_0002);

    // 3: simultaneous requests from reset alternate grants
    clear = 1'b0;
    tick();
    clear = 1'b1;
    set_req(0, 1'b1, 32'h1234_5678, 5'd4, 1'b0);
    set_req(1, 1'b1, 32'h0000_000F, 5'd8, 1'b0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    sample();
    chk("t3_first_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    chk("t3_first_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    sample();
    chk("t3_exec_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    sample();
    chk("t3_rsp0_data", bus.rsp0_data, 32'h8123_4567);
    chk("t3_hold_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    bus.req0_valid = 1'b1;
    sample();
    chk("t3_second_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
    chk("t3_second_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    sample();
    chk("t3_rsp1_data", bus.rsp1_data, 32'h0F00_0000);
    chk("t3_rsp0_valid_idle", {31'd0, bus.rsp0_valid}, 32'd0);
    tick();
    bus.req1_valid = 1'b1;
    sample();
    chk("t3_third_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    chk("t3_third_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    sample();
    chk("t3_third_rsp0_data", bus.rsp0_data, 32'h8123_4567);
    tick();
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    sample();
    chk("t3_ops_done", {28'd0, ops_done}, 32'd3);

    // 4: backpressure on rsp0 blocks req1
    tick();
    set_req(0, 1'b1, 32'hDEAD_BEEF, 5'd16, 1'b0);
    sample();
    chk("t4_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    set_req(1, 1'b1, 32'h0000_0001, 5'd31, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      sample();
      chk($sformatf("t4_bp_valid%0d", i), {31'd0, bus.rsp0_valid}, 32'd1);
      chk($sformatf("t4_bp_data%0d", i), bus.rsp0_data, 32'hBEEF_DEAD);
      chk($sformatf("t4_bp_req1_ready%0d", i), {31'd0, bus.req1_ready}, 32'd0);
      tick();
    end
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    sample();
    chk("t4_rsp0_valid_clr", {31'd0, bus.rsp0_valid}, 32'd0);
    chk("t4_req1_granted", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    bus.rsp1_ready = 1'b1;
    tick();
    sample();
    chk("t4_rsp1_data", bus.rsp1_data, 32'h8000_0000);
    tick();
    bus.rsp1_ready = 1'b0;
    sample();
    chk("t4_ops_done", {28'd0, ops_done}, 32'd5);

    // 5a: reset during EXEC
    tick();
    set_req(0, 1'b1, 32'h0000_0001, 5'd1, 1'b0);
    bus.rsp0_ready = 1'b1;
    sample();
    chk("t5a_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    clear = 1'b0;
    sample();
    chk("t5a_busy_exec", {31'd0, busy}, 32'd1);
    tick();
    sample();
    chk("t5a_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    chk("t5a_busy", {31'd0, busy}, 32'd0);
    chk("t5a_ops_done", {28'd0, ops_done}, 32'd0);
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk($sformatf("t5a_stale%0d", i), {31'd0, bus.rsp0_valid}, 32'd0);
    end
    bus.rsp0_ready = 1'b0;

    // 5b: reset during HOLD
    tick();
    set_req(1, 1'b1, 32'h0000_000F, 5'd4, 1'b0);
    sample();
    chk("t5b_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    sample();
    chk("t5b_rsp1_valid_hold", {31'd0, bus.rsp1_valid}, 32'd1);
    chk("t5b_rsp1_data_hold", bus.rsp1_data, 32'hF000_0000);
    tick();
    clear = 1'b0;
    tick();
    sample();
    chk("t5b_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    chk("t5b_rsp1_data", bus.rsp1_data, 32'd0);
    chk("t5b_busy", {31'd0, busy}, 32'd0);
    chk("t5b_ops_done", {28'd0, ops_done}, 32'd0);
    clear = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk($sformatf("t5b_stale%0d", i), {31'd0, bus.rsp1_valid}, 32'd0);
    end
    bus.rsp1_ready = 1'b0;
    tick();
    set_req(0, 1'b1, 32'h0, 5'd0, 1'b0);
    set_req(1, 1'b1, 32'h0, 5'd0, 1'b0);
    sample();
    chk("t5b_prio_req0", {31'd0, bus.req0_ready}, 32'd1);
    chk("t5b_prio_req1", {31'd0, bus.req1_ready}, 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // 6: counter wraps modulo 16
    for (int i = 0; i < 17; i++)
      run_op($sformatf("t6_op%0d", i), i % 2, 32'h0000_0003, 5'd1, 1'b0, 32'h8000_0001);
    sample();
    chk("t6_ops_done_wrap", {28'd0, ops_done}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
